vending_machine_multi: RTL and testbench

Parametrised successor to the single-product coin vending FSM: accepts three coin denominations, holds a running credit, vends one of `NPROD` products on request, and returns change serially as a sequence of coin codes. Sits directly between the coin acceptor, the product selector and the dispense/coin-return actuators; all outputs are registered.

---
 rtl/vending_machine_multi_if.sv | 44 ++++
 rtl/vending_machine_multi.sv | 188 ++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vending_machine_multi_if
//   Bundles the coin/selector/actuator signals of vending_machine_multi.
//   Signals:
//     in          [1:0]      coin code from the acceptor (00 = none)
//     sel         [SEL_W-1]  product select, sampled together with buy
//     buy                    purchase request
//     cancel                 refund request
//     out                    one-cycle dispense pulse
//     vend_id     [SEL_W-1]  product being dispensed (held between vends)
//     change      [1:0]      returned coin code, one per cycle
//     credit      [CREDIT_W] current credit
//     coin_reject            one-cycle pulse when a coin is refused
//     busy                   machine is vending or paying out change
//   Modports: master drives requests and observes status (acceptor/panel
//   side); slave is the vending controller.
// ---------------------------------------------------------------------------
interface vending_machine_multi_if #(
  parameter int NPROD    = 4,
  parameter int CREDIT_W = 8
);
  localparam int SEL_W = (NPROD > 1) ? $clog2(NPROD) : 1;

  logic [1:0]          in;
  logic [SEL_W-1:0]    sel;
  logic                buy;
  logic                cancel;
  logic                out;
  logic [SEL_W-1:0]    vend_id;
  logic [1:0]          change;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                busy;

  modport master (
    output in, sel, buy, cancel,
    input  out, vend_id, change, credit, coin_reject, busy
  );

  modport slave (
    input  in, sel, buy, cancel,
    output out, vend_id, change, credit, coin_reject, busy
  );
endinterface

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//   Multi-product coin vending controller. Accepts three coin denominations
//   into a running credit, vends one of NPROD products when the credit covers
//   its price, and pays out the remainder one coin per cycle (largest coin
//   first). All outputs come straight from flops.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    vending_machine_multi_if.slave (coin, select, buy, cancel in;
//            out, vend_id, change, credit, coin_reject, busy out)
//
//   Optional feature macro: VM_CANCEL_EN
//     defined   -> cancel in IDLE with nonzero credit refunds the credit
//                  through the change sequence (takes priority over buy)
//     undefined -> cancel is ignored
// ---------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int                          CREDIT_W   = 8,
  parameter int                          COIN_A     = 5,
  parameter int                          COIN_B     = 10,
  parameter int                          COIN_C     = 20,
  parameter int                          NPROD      = 4,
  parameter logic [NPROD*CREDIT_W-1:0]   PRICES     = {8'd35, 8'd25, 8'd20, 8'd15},
  parameter int                          MAX_CREDIT = 60
) (
  input logic                    clk,
  input logic                    rst_n,
  vending_machine_multi_if.slave bus
);

  localparam int SEL_W = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [CREDIT_W-1:0] VAL_A   = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] VAL_B   = CREDIT_W'(COIN_B);
  localparam logic [CREDIT_W-1:0] VAL_C   = CREDIT_W'(COIN_C);
  localparam logic [SUM_W-1:0]    MAX_SUM = SUM_W'(MAX_CREDIT);

`ifdef VM_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic [1:0]          change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  // Unpacked view of the packed price table.
  logic [CREDIT_W-1:0] price_tbl [NPROD];

  genvar gi;
  generate
    for (gi = 0; gi < NPROD; gi++) begin : g_price
      assign price_tbl[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
    end
  endgenerate

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = VAL_A;
      2'b10:   coin_value = VAL_B;
      2'b11:   coin_value = VAL_C;
      default: coin_value = '0;
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit; 00 if none fits.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] rem);
    if (rem >= VAL_C)      pick_coin = 2'b11;
    else if (rem >= VAL_B) pick_coin = 2'b10;
    else if (rem >= VAL_A) pick_coin = 2'b01;
    else                   pick_coin = 2'b00;
  endfunction

  // Price of the selected product. A select beyond NPROD never buys.
  logic [CREDIT_W-1:0] price_sel;
  logic                sel_ok;

  always_comb begin
    price_sel = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NPROD; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        price_sel = price_tbl[i];
        sel_ok    = 1'b1;
      end
    end
  end

  logic [SUM_W-1:0]    coin_sum;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] change_val;
  logic                coin_in;

  assign coin_in     = (bus.in != 2'b00);
  // One extra bit so a full credit plus a coin cannot wrap before the compare.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value(bus.in)};
  assign change_coin = pick_coin(credit_q);
  assign change_val  = coin_value(change_coin);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    out_d         = 1'b0;
    vend_id_d     = vend_id_q;
    change_d      = 2'b00;
    coin_reject_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CANCEL_EN && bus.cancel && (credit_q != '0)) begin
          // Refund: first coin goes out on the same edge that leaves IDLE.
          state_d       = ST_CHANGE;
          change_d      = change_coin;
          credit_d      = credit_q - change_val;
          coin_reject_d = coin_in;
        end else if (bus.buy && sel_ok && (credit_q >= price_sel)) begin
          state_d       = ST_VEND;
          out_d         = 1'b1;
          vend_id_d     = bus.sel;
          credit_d      = credit_q - price_sel;
          coin_reject_d = coin_in;
        end else if (coin_in) begin
          if (coin_sum <= MAX_SUM) credit_d = coin_sum[CREDIT_W-1:0];
          else                     coin_reject_d = 1'b1;
        end
      end

      ST_VEND, ST_CHANGE: begin
        coin_reject_d = coin_in;
        if (credit_q != '0) begin
          state_d  = ST_CHANGE;
          change_d = change_coin;
          // A remainder below the smallest coin cannot be paid out; drop it
          // rather than stall (cannot occur with legal parameters).
          credit_d = (change_coin == 2'b00) ? '0 : credit_q - change_val;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      out_q         <= 1'b0;
      vend_id_q     <= '0;
      change_q      <= 2'b00;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      out_q         <= out_d;
      vend_id_q     <= vend_id_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.change      = change_q;
  assign bus.credit      = credit_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
//   Directed bench for vending_machine_multi (default parameters). A
//   behavioural model keeps the credit as an integer and, on a vend or
//   refund, schedules the whole future output sequence in a queue; a
//   compare process checks every output against it on each falling edge.
//   Hand-computed literal checks along the way pin the model.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

`ifdef VM_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vending_machine_multi_if #(.NPROD(4), .CREDIT_W(8)) bus ();

  vending_machine_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit out;
    int vid;
    int chg;
    int credit;
    bit busy;
  } exp_t;

  int   price [4] = '{15, 20, 25, 35};
  exp_t cur = '{0, 0, 0, 0, 0};
  exp_t pend [$];
  bit   rej = 1'b0;
  int   m_cr, m_vid, m_rem, m_c;

  function automatic int coin_val(input int code);
    case (code)
      1:       return 5;
      2:       return 10;
      3:       return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(input int r);
    if (r >= 20) return 3;
    if (r >= 10) return 2;
    if (r >= 5)  return 1;
    return 0;
  endfunction

  // Queue one cycle per change coin, greedy largest-first.
  task automatic push_change(input int r, input int vid);
    int c;
    while (r > 0) begin
      c = pick(r);
      r = r - coin_val(c);
      pend.push_back('{0, vid, c, r, 1});
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = '{0, 0, 0, 0, 0};
      pend.delete();
      rej = 1'b0;
    end else begin
      m_cr  = cur.credit;
      m_vid = cur.vid;
      rej   = 1'b0;
      if (cur.busy) begin
        rej = (bus.in != 0);
        if (pend.size() > 0) cur = pend.pop_front();
        else                 cur = '{0, m_vid, 0, m_cr, 0};
      end else begin
        cur = '{0, m_vid, 0, m_cr, 0};
        if (CANCEL_EN && bus.cancel && m_cr > 0) begin
          rej = (bus.in != 0);
          push_change(m_cr, m_vid);
          cur = pend.pop_front();
        end else if (bus.buy && m_cr >= price[bus.sel]) begin
          rej   = (bus.in != 0);
          m_rem = m_cr - price[bus.sel];
          cur   = '{1, int'(bus.sel), 0, m_rem, 1};
          push_change(m_rem, int'(bus.sel));
        end else if (bus.in != 0) begin
          m_c = coin_val(int'(bus.in));
          if (m_cr + m_c <= 60) cur.credit = m_cr + m_c;
          else                  rej = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out",         int'(bus.out),         int'(cur.out));
      chk("vend_id",     int'(bus.vend_id),     cur.vid);
      chk("change",      int'(bus.change),      cur.chg);
      chk("credit",      int'(bus.credit),      cur.credit);
      chk("coin_reject", int'(bus.coin_reject), int'(rej));
      chk("busy",        int'(bus.busy),        int'(cur.busy));
    end
  end

  // Apply one cycle of inputs (called at a falling edge), return at the
  // next falling edge with the resulting outputs settled.
  task automatic step(input int coin, input int sel, input bit buy, input bit cancel);
    bus.in     = 2'(coin);
    bus.sel    = 2'(sel);
    bus.buy    = buy;
    bus.cancel = cancel;
    @(negedge clk);
  endtask

  initial begin
    bus.in = 2'b00; bus.sel = 2'b00; bus.buy = 1'b0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_busy",   int'(bus.busy),   0);
    chk("rst_out",    int'(bus.out),    0);

    // 10 + 10, buy product 0 (15) -> remainder 5
    step(2, 0, 0, 0);
    step(2, 0, 0, 0);
    chk("t1_credit20", int'(bus.credit), 20);
    step(0, 0, 1, 0);
    chk("t1_out", int'(bus.out), 1);
    chk("t1_rem", int'(bus.credit), 5);
    step(0, 0, 0, 0);
    chk("t1_chg_a", int'(bus.change), 1);
    step(0, 0, 0, 0);
    chk("t1_idle_chg", int'(bus.change), 0);
    chk("t1_idle_busy", int'(bus.busy), 0);

    // fill to 60, overflow coin rejected, buy product 2 (25) -> 35 back
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    chk("t2_credit60", int'(bus.credit), 60);
    step(3, 0, 0, 0);
    chk("t2_reject", int'(bus.coin_reject), 1);
    chk("t2_hold60", int'(bus.credit), 60);
    step(0, 2, 1, 0);
    chk("t2_out", int'(bus.out), 1);
    chk("t2_vid", int'(bus.vend_id), 2);
    step(0, 0, 0, 0);
    chk("t2_chg_c", int'(bus.change), 3);
    step(0, 0, 0, 0);
    chk("t2_chg_b", int'(bus.change), 2);
    step(0, 0, 0, 0);
    chk("t2_chg_a", int'(bus.change), 1);
    step(0, 0, 0, 0);
    chk("t2_done", int'(bus.busy), 0);

    // short buy with a coin in the same cycle, then exact-price vend,
    // coin during VEND is refused
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("t3_no_out", int'(bus.out), 0);
    chk("t3_credit15", int'(bus.credit), 15);
    step(0, 0, 1, 0);
    chk("t3_out", int'(bus.out), 1);
    step(2, 0, 0, 0);
    chk("t3_vend_rej", int'(bus.coin_reject), 1);
    chk("t3_credit0", int'(bus.credit), 0);

    // coin during CHANGE is refused, sequence continues
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t4_chg_c", int'(bus.change), 3);
    step(2, 0, 0, 0);
    chk("t4_rej", int'(bus.coin_reject), 1);
    chk("t4_chg_a", int'(bus.change), 1);
    step(0, 0, 0, 0);
    chk("t4_done_credit", int'(bus.credit), 0);

    // cancel at 30
    step(3, 0, 0, 0);
    step(2, 0, 0, 0);
    step(0, 0, 0, 1);
`ifdef VM_CANCEL_EN
    chk("t5_chg_c", int'(bus.change), 3);
    chk("t5_no_out", int'(bus.out), 0);
    step(0, 0, 0, 0);
    chk("t5_chg_b", int'(bus.change), 2);
    step(0, 0, 0, 0);
    chk("t5_credit0", int'(bus.credit), 0);
`else
    chk("t5_hold30", int'(bus.credit), 30);
    chk("t5_idle", int'(bus.busy), 0);
    step(0, 2, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
`endif

    // asynchronous reset in the middle of a change sequence
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t6_mid_chg", int'(bus.change), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_credit", int'(bus.credit), 0);
    chk("t6_async_busy",   int'(bus.busy),   0);
    chk("t6_async_change", int'(bus.change), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk("t6_after_rst", int'(bus.credit), 5);
    step(0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
